// File: rtl/lc3b_regfile_sb_if.sv
// LC-3b register file bus: SR-stage writeback, decode read ports,
// decode issue reservations and scoreboard status.
// master = SR/decode side, slave = register file.
interface lc3b_regfile_sb_if #(
  parameter int DW = 16
);
  logic          v_sr_ld_reg;
  logic [2:0]    sr_drid;
  logic [DW-1:0] sr_reg_data;
  logic          v_sr_ld_cc;
  logic [2:0]    sr_cc_data;
  logic [2:0]    de_sr1id;
  logic [2:0]    de_sr2id;
  logic [DW-1:0] de_sr1;
  logic [DW-1:0] de_sr2;
  logic [2:0]    de_cc;
  logic          de_issue;
  logic          de_issue_ld_reg;
  logic [2:0]    de_issue_drid;
  logic          de_issue_ld_cc;
  logic          de_sr1_busy;
  logic          de_sr2_busy;
  logic          de_cc_busy;
  logic          de_drid_full;
  logic          de_cc_full;
  logic          sb_err;

  modport master (
    output v_sr_ld_reg, sr_drid, sr_reg_data, v_sr_ld_cc, sr_cc_data,
    output de_sr1id, de_sr2id, de_issue, de_issue_ld_reg, de_issue_drid, de_issue_ld_cc,
    input  de_sr1, de_sr2, de_cc, de_sr1_busy, de_sr2_busy, de_cc_busy,
    input  de_drid_full, de_cc_full, sb_err
  );

  modport slave (
    input  v_sr_ld_reg, sr_drid, sr_reg_data, v_sr_ld_cc, sr_cc_data,
    input  de_sr1id, de_sr2id, de_issue, de_issue_ld_reg, de_issue_drid, de_issue_ld_cc,
    output de_sr1, de_sr2, de_cc, de_sr1_busy, de_sr2_busy, de_cc_busy,
    output de_drid_full, de_cc_full, sb_err
  );
endinterface

// File: rtl/lc3b_regfile_sb.sv
// LC-3b architectural register file (R0-R7 + NZP) with a pending-write
// scoreboard for RAW hazard detection in decode.
// Optional macro RF_BYPASS_EN: same-cycle write-through of SR writeback
// data to the read ports / CC, and busy drops in the final-retire cycle.
module lc3b_regfile_sb #(
  parameter int          DW       = 16,
  parameter int          PEND_W   = 2,
  parameter logic [2:0]  RESET_CC = 3'b010
) (
  input  logic                clk,
  input  logic                rst_n,
  lc3b_regfile_sb_if.slave    bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam int                CC_IDX   = 8;

  logic [DW-1:0]     r_regs [8];
  logic [2:0]        r_cc;
  logic [PEND_W-1:0] r_pend [9];
  logic              r_sbErr;

  logic [8:0]        w_inc;
  logic [8:0]        w_dec;
  logic [8:0]        w_busy;
  logic [PEND_W-1:0] w_pendNext [9];
  logic              w_errSet;

  // Decode which scoreboard entries are being reserved (issue) and retired (SR write)
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int t = 0; t < 8; t++) begin
      w_inc[t] = bus.de_issue && bus.de_issue_ld_reg && (bus.de_issue_drid == 3'(t));
      w_dec[t] = bus.v_sr_ld_reg && (bus.sr_drid == 3'(t));
    end
    w_inc[CC_IDX] = bus.de_issue && bus.de_issue_ld_cc;
    w_dec[CC_IDX] = bus.v_sr_ld_cc;
  end

  // Next pending counts; saturate at MAX and floor at 0, flagging either as an error
  always_comb begin
    w_errSet = 1'b0;
    for (int t = 0; t < 9; t++) begin
      w_pendNext[t] = r_pend[t];
      if (w_inc[t] && !w_dec[t]) begin
        if (r_pend[t] == PEND_MAX) w_errSet = 1'b1;
        else                       w_pendNext[t] = r_pend[t] + PEND_W'(1);
      end else if (w_dec[t] && !w_inc[t]) begin
        if (r_pend[t] == '0) w_errSet = 1'b1;
        else                 w_pendNext[t] = r_pend[t] - PEND_W'(1);
      end
    end
  end

  // Scoreboard counters and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < 9; t++) r_pend[t] <= '0;
      r_sbErr <= 1'b0;
    end else begin
      for (int t = 0; t < 9; t++) r_pend[t] <= w_pendNext[t];
      if (w_errSet) r_sbErr <= 1'b1;
    end
  end

  // Architectural registers and condition codes, written by the SR stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) r_regs[r] <= '0;
      r_cc <= RESET_CC;
    end else begin
      if (bus.v_sr_ld_reg) r_regs[bus.sr_drid] <= bus.sr_reg_data;
      if (bus.v_sr_ld_cc)  r_cc <= bus.sr_cc_data;
    end
  end

`ifdef RF_BYPASS_EN
  // Busy, except when the last outstanding writer retires this cycle (its data is forwarded)
  always_comb begin
    w_busy = '0;
    for (int t = 0; t < 9; t++)
      w_busy[t] = (r_pend[t] != '0) && !(w_dec[t] && (r_pend[t] == PEND_W'(1)));
  end

  assign bus.de_sr1 = (bus.v_sr_ld_reg && (bus.sr_drid == bus.de_sr1id)) ? bus.sr_reg_data
                                                                           : r_regs[bus.de_sr1id];
  assign bus.de_sr2 = (bus.v_sr_ld_reg && (bus.sr_drid == bus.de_sr2id)) ? bus.sr_reg_data
                                                                           : r_regs[bus.de_sr2id];
  assign bus.de_cc  = bus.v_sr_ld_cc ? bus.sr_cc_data : r_cc;
`else
  // Busy whenever any writer is still outstanding
  always_comb begin
    w_busy = '0;
    for (int t = 0; t < 9; t++)
      w_busy[t] = (r_pend[t] != '0);
  end

  assign bus.de_sr1 = r_regs[bus.de_sr1id];
  assign bus.de_sr2 = r_regs[bus.de_sr2id];
  assign bus.de_cc  = r_cc;
`endif

  assign bus.de_sr1_busy  = w_busy[bus.de_sr1id];
  assign bus.de_sr2_busy  = w_busy[bus.de_sr2id];
  assign bus.de_cc_busy   = w_busy[CC_IDX];
  assign bus.de_drid_full = (r_pend[bus.de_issue_drid] == PEND_MAX);
  assign bus.de_cc_full   = (r_pend[CC_IDX] == PEND_MAX);
  assign bus.sb_err       = r_sbErr;

endmodule

// File: tb/tb_lc3b_regfile_sb.sv
// Directed self-checking bench for lc3b_regfile_sb.
// Expectations that differ with RF_BYPASS_EN are selected at compile time.
module tb_lc3b_regfile_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lc3b_regfile_sb_if #(.DW(16)) bus ();

  lc3b_regfile_sb #(.DW(16), .PEND_W(2), .RESET_CC(3'b010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive every input to its idle value
  task automatic idle;
    bus.v_sr_ld_reg     = 1'b0;
    bus.sr_drid         = 3'd0;
    bus.sr_reg_data     = 16'h0000;
    bus.v_sr_ld_cc      = 1'b0;
    bus.sr_cc_data      = 3'b000;
    bus.de_sr1id        = 3'd0;
    bus.de_sr2id        = 3'd0;
    bus.de_issue        = 1'b0;
    bus.de_issue_ld_reg = 1'b0;
    bus.de_issue_drid   = 3'd0;
    bus.de_issue_ld_cc  = 1'b0;
  endtask

  // Hold reset for two edges, release just after an edge
  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Issue a register-writing instruction to drid for one cycle
  task automatic issue_reg(input logic [2:0] drid);
    bus.de_issue = 1'b1; bus.de_issue_ld_reg = 1'b1; bus.de_issue_drid = drid;
    step();
    bus.de_issue = 1'b0; bus.de_issue_ld_reg = 1'b0;
  endtask

  // SR writeback of data to drid for one cycle
  task automatic sr_write(input logic [2:0] drid, input logic [15:0] data);
    bus.v_sr_ld_reg = 1'b1; bus.sr_drid = drid; bus.sr_reg_data = data;
    step();
    bus.v_sr_ld_reg = 1'b0;
  endtask

  // Async reset mid-cycle clears state immediately
  task automatic test_reset;
    do_reset();
    bus.de_sr1id = 3'd0; bus.de_sr2id = 3'd7; bus.de_issue_drid = 3'd7;
    bus.de_issue = 1'b1; bus.de_issue_ld_reg = 1'b1; bus.de_issue_drid = 3'd7;
    bus.v_sr_ld_reg = 1'b1; bus.sr_drid = 3'd0; bus.sr_reg_data = 16'h1234;
    bus.v_sr_ld_cc = 1'b1; bus.sr_cc_data = 3'b001;
    step();
    idle();
    bus.de_sr1id = 3'd0; bus.de_sr2id = 3'd7; bus.de_issue_drid = 3'd7;
    #1;
    checks++; if (bus.de_sr1 !== 16'h1234) begin errors++; $display("[TB] FAIL pre_reset_r0 got %h want %h", bus.de_sr1, 16'h1234); end
    checks++; if (bus.de_sr2_busy !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_busy got %b want 1", bus.de_sr2_busy); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.de_sr1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sr1 got %h want 0000", bus.de_sr1); end
    checks++; if (bus.de_cc !== 3'b010) begin errors++; $display("[TB] FAIL reset_cc got %b want 010", bus.de_cc); end
    checks++; if (bus.de_sr2_busy !== 1'b0 || bus.de_sr1_busy !== 1'b0 || bus.de_cc_busy !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_busy got %b%b%b want 000", bus.de_sr1_busy, bus.de_sr2_busy, bus.de_cc_busy); end
    checks++; if (bus.de_drid_full !== 1'b0 || bus.de_cc_full !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_full got %b%b want 00", bus.de_drid_full, bus.de_cc_full); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sberr got %b want 0", bus.sb_err); end
    step();
    rst_n = 1'b1;
  endtask

  // Basic write then read on both ports, plus underflow on an unreserved write
  task automatic test_write_read;
    do_reset();
    bus.de_sr1id = 3'd3; bus.de_sr2id = 3'd4;
    bus.v_sr_ld_reg = 1'b1; bus.sr_drid = 3'd3; bus.sr_reg_data = 16'hBEEF;
    #1;
    checks++; if (bus.de_sr1 !== (BYP ? 16'hBEEF : 16'h0000))
      begin errors++; $display("[TB] FAIL wr_same_cycle got %h want %h", bus.de_sr1, (BYP ? 16'hBEEF : 16'h0000)); end
    step();
    bus.v_sr_ld_reg = 1'b0;
    #1;
    checks++; if (bus.de_sr1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_r3 got %h want BEEF", bus.de_sr1); end
    checks++; if (bus.de_sr2 !== 16'h0000) begin errors++; $display("[TB] FAIL rd_r4 got %h want 0000", bus.de_sr2); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("[TB] FAIL wr_underflow got %b want 1", bus.sb_err); end
  endtask

  // Two reservations on R5 then two retirements
  task automatic test_scoreboard;
    do_reset();
    bus.de_sr1id = 3'd5;
    issue_reg(3'd5);
    checks++; if (bus.de_sr1_busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_busy1 got %b want 1", bus.de_sr1_busy); end
    issue_reg(3'd5);
    bus.de_issue_drid = 3'd5;
    #1;
    checks++; if (bus.de_sr1_busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_busy2 got %b want 1", bus.de_sr1_busy); end
    checks++; if (bus.de_drid_full !== 1'b0) begin errors++; $display("[TB] FAIL sb_notfull got %b want 0", bus.de_drid_full); end
    sr_write(3'd5, 16'h1111);
    checks++; if (bus.de_sr1_busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_busy_after1 got %b want 1", bus.de_sr1_busy); end
    bus.v_sr_ld_reg = 1'b1; bus.sr_drid = 3'd5; bus.sr_reg_data = 16'h2222;
    #1;
    checks++; if (bus.de_sr1_busy !== (BYP ? 1'b0 : 1'b1))
      begin errors++; $display("[TB] FAIL sb_busy_final_cycle got %b want %b", bus.de_sr1_busy, (BYP ? 1'b0 : 1'b1)); end
    checks++; if (bus.de_sr1 !== (BYP ? 16'h2222 : 16'h1111))
      begin errors++; $display("[TB] FAIL sb_data_final_cycle got %h want %h", bus.de_sr1, (BYP ? 16'h2222 : 16'h1111)); end
    step();
    bus.v_sr_ld_reg = 1'b0;
    #1;
    checks++; if (bus.de_sr1_busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_busy_clear got %b want 0", bus.de_sr1_busy); end
    checks++; if (bus.de_sr1 !== 16'h2222) begin errors++; $display("[TB] FAIL sb_data got %h want 2222", bus.de_sr1); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("[TB] FAIL sb_err_clean got %b want 0", bus.sb_err); end
  endtask

  // Saturate R2 at 3 pending writers, overflow, then drain
  task automatic test_saturation;
    do_reset();
    bus.de_sr2id = 3'd2;
    issue_reg(3'd2);
    issue_reg(3'd2);
    bus.de_issue_drid = 3'd2;
    #1;
    checks++; if (bus.de_drid_full !== 1'b0) begin errors++; $display("[TB] FAIL sat_at2 got %b want 0", bus.de_drid_full); end
    issue_reg(3'd2);
    bus.de_issue_drid = 3'd2;
    #1;
    checks++; if (bus.de_drid_full !== 1'b1) begin errors++; $display("[TB] FAIL sat_full got %b want 1", bus.de_drid_full); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("[TB] FAIL sat_noerr got %b want 0", bus.sb_err); end
    bus.de_issue_drid = 3'd1;
    #1;
    checks++; if (bus.de_drid_full !== 1'b0) begin errors++; $display("[TB] FAIL sat_other_id got %b want 0", bus.de_drid_full); end
    issue_reg(3'd2);
    bus.de_issue_drid = 3'd2;
    #1;
    checks++; if (bus.de_drid_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b want 1", bus.de_drid_full); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err got %b want 1", bus.sb_err); end
    sr_write(3'd2, 16'h0001);
    sr_write(3'd2, 16'h0002);
    checks++; if (bus.de_sr2_busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy got %b want 1", bus.de_sr2_busy); end
    sr_write(3'd2, 16'h0003);
    checks++; if (bus.de_sr2_busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_clear got %b want 0", bus.de_sr2_busy); end
    checks++; if (bus.de_sr2 !== 16'h0003) begin errors++; $display("[TB] FAIL drain_data got %h want 0003", bus.de_sr2); end
  endtask

  // Issue and retire on the same target in one cycle; then an unreserved write
  task automatic test_simultaneous;
    do_reset();
    bus.de_sr1id = 3'd6; bus.de_sr2id = 3'd1;
    issue_reg(3'd6);
    bus.de_issue = 1'b1; bus.de_issue_ld_reg = 1'b1; bus.de_issue_drid = 3'd6;
    bus.v_sr_ld_reg = 1'b1; bus.sr_drid = 3'd6; bus.sr_reg_data = 16'h8001;
    step();
    idle();
    bus.de_sr1id = 3'd6; bus.de_sr2id = 3'd1;
    #1;
    checks++; if (bus.de_sr1_busy !== 1'b1) begin errors++; $display("[TB] FAIL simul_busy got %b want 1", bus.de_sr1_busy); end
    checks++; if (bus.de_sr1 !== 16'h8001) begin errors++; $display("[TB] FAIL simul_data got %h want 8001", bus.de_sr1); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("[TB] FAIL simul_noerr got %b want 0", bus.sb_err); end
    sr_write(3'd1, 16'h00AA);
    checks++; if (bus.de_sr2 !== 16'h00AA) begin errors++; $display("[TB] FAIL unf_data got %h want 00AA", bus.de_sr2); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("[TB] FAIL unf_err got %b want 1", bus.sb_err); end
    checks++; if (bus.de_sr2_busy !== 1'b0) begin errors++; $display("[TB] FAIL unf_busy got %b want 0", bus.de_sr2_busy); end
    sr_write(3'd6, 16'h7777);
    checks++; if (bus.de_sr1_busy !== 1'b0) begin errors++; $display("[TB] FAIL simul_drain got %b want 0", bus.de_sr1_busy); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", bus.sb_err); end
  endtask

  // Condition-code reservation, writeback and saturation
  task automatic test_cc;
    do_reset();
    bus.de_issue = 1'b1; bus.de_issue_ld_cc = 1'b1;
    step();
    idle();
    #1;
    checks++; if (bus.de_cc_busy !== 1'b1) begin errors++; $display("[TB] FAIL cc_busy got %b want 1", bus.de_cc_busy); end
    checks++; if (bus.de_cc_full !== 1'b0) begin errors++; $display("[TB] FAIL cc_notfull got %b want 0", bus.de_cc_full); end
    bus.v_sr_ld_cc = 1'b1; bus.sr_cc_data = 3'b100;
    #1;
    checks++; if (bus.de_cc !== (BYP ? 3'b100 : 3'b010))
      begin errors++; $display("[TB] FAIL cc_same_cycle got %b want %b", bus.de_cc, (BYP ? 3'b100 : 3'b010)); end
    checks++; if (bus.de_cc_busy !== (BYP ? 1'b0 : 1'b1))
      begin errors++; $display("[TB] FAIL cc_busy_cycle got %b want %b", bus.de_cc_busy, (BYP ? 1'b0 : 1'b1)); end
    step();
    idle();
    #1;
    checks++; if (bus.de_cc !== 3'b100) begin errors++; $display("[TB] FAIL cc_value got %b want 100", bus.de_cc); end
    checks++; if (bus.de_cc_busy !== 1'b0) begin errors++; $display("[TB] FAIL cc_clear got %b want 0", bus.de_cc_busy); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("[TB] FAIL cc_noerr got %b want 0", bus.sb_err); end
    bus.de_issue = 1'b1; bus.de_issue_ld_cc = 1'b1;
    step(); step(); step();
    idle();
    #1;
    checks++; if (bus.de_cc_full !== 1'b1) begin errors++; $display("[TB] FAIL cc_full got %b want 1", bus.de_cc_full); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("[TB] FAIL cc_full_noerr got %b want 0", bus.sb_err); end
  endtask

  // Test sequence
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    $display("[TB] start, bypass=%0d", BYP);
    test_reset();
    test_write_read();
    test_scoreboard();
    test_saturation();
    test_simultaneous();
    test_cc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
